// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding and default requester count.
package uart_pkg;

    localparam int N_REQ_DEFAULT = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_START   = 2'd1;
    localparam state_t ST_BUSY    = 2'd2;
    localparam state_t ST_RELEASE = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] j;

    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!valid && req[j]) begin
                valid     = 1'b1;
                winner[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ requesters.
// Defining UART_ARB_TIMEOUT_EN adds a per-transfer abort after TIMEOUT_CYCLES clocks.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               send,
    output logic [7:0]         data_out,
    input  logic               tx_active,
    input  logic               tx_done
);

    localparam int IW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [7:0]       data_q, data_d;

    logic [N_REQ-1:0] pick_win;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [7:0]       pick_data;

`ifdef UART_ARB_TIMEOUT_EN
    logic [N_REQ-1:0] err_q, err_d;
    logic [31:0]      cnt_q, cnt_d;
`endif

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_win),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) pick_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        done_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
        err_d   = '0;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_win;
                    idx_d   = pick_idx;
                    data_d  = pick_data;
                    state_d = ST_START;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            // tx_done seen here is left over from an earlier frame and is ignored
            ST_START: begin
                if (tx_active) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_done) begin
                    done_d  = grant_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                ptr_d   = idx_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        // A genuine completion in the same cycle as expiry takes precedence over the abort
        if (state_q == ST_START || state_q == ST_BUSY) begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == 32'(TIMEOUT_CYCLES - 1) && !(state_q == ST_BUSY && tx_done)) begin
                err_d   = grant_q;
                grant_d = '0;
                ptr_d   = idx_q;
                state_d = ST_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            data_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign send     = (state_q == ST_START);
    assign data_out = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = '0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, clk cycles allowed per transfer before abort (used only under REQ-027).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 arst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  N_REQ  per-requester transfer request, level.
REQ-006 req_data  input  8*N_REQ  byte per requester; slice i = bits [8i+7:8i].
REQ-007 grant  output  N_REQ  one-hot owner of the transmitter, all-zero when idle.
REQ-008 done  output  N_REQ  one-cycle pulse to owner when its byte has completed.
REQ-009 err  output  N_REQ  one-cycle pulse to owner on timeout abort.
REQ-010 send  output  1  drives uart_tx send.
REQ-011 data_out  output  8  drives uart_tx data_in; held stable while grant is non-zero.
REQ-012 tx_active  input  1  from uart_tx; high while a frame shifts out.
REQ-013 tx_done  input  1  from uart_tx; high when frame complete; synchronous to clk.

Function
REQ-014 FSM states IDLE, START, BUSY, RELEASE; reset state IDLE.
REQ-015 IDLE: if req non-zero, select winner round-robin starting at index ptr+1 (mod N_REQ), latch its req_data slice into data_out, set grant one-hot, go START next cycle.
REQ-016 IDLE with req all-zero: remain IDLE; grant, send, done, err all 0.
REQ-017 START: send=1; on tx_active=1 go BUSY (send drops on that edge).
REQ-018 BUSY: send=0; on tx_done=1 go RELEASE.
REQ-019 RELEASE: done[winner]=1 for exactly one cycle, grant cleared, ptr=winner, go IDLE.
REQ-020 Latency: req asserted in idle cycle n -> grant and data_out valid at n+1, send high at n+1.
REQ-021 Back-to-back: a request pending in RELEASE is arbitrated in the following IDLE cycle; minimum gap between done pulses equals one full frame plus 3 cycles.
REQ-022 Requester deasserting req while granted: ignored; transfer completes, done still pulses.
REQ-023 Requests arriving during START/BUSY/RELEASE are not lost; they win by round-robin order once IDLE.
REQ-024 tx_done high while in START (stale): ignored; only tx_done in BUSY ends a transfer.
REQ-025 Fairness: with all req held high, grant order is 0,1,...,N_REQ-1,0,... after reset.

Reset
REQ-026 arst_n=0 at a rising edge forces next cycle: state IDLE, ptr=N_REQ-1, grant=0, send=0, done=0, err=0, data_out=0, timeout counter=0; applies mid-transfer with no done pulse.

Configuration
REQ-027 Macro UART_ARB_TIMEOUT_EN defined: counter runs in START and BUSY, clears on entering START; on reaching TIMEOUT_CYCLES, err[winner] pulses one cycle, done not pulsed, send=0, grant cleared, ptr=winner, state IDLE.
REQ-028 Macro undefined: no counter logic; err tied to 0; START/BUSY wait indefinitely.

Structure
REQ-029 Shared package uart_pkg holds the state enumeration and the default N_REQ constant.
REQ-030 Round-robin selection is a sub-module rr_picker (inputs req, ptr; outputs one-hot winner and index).

Verification
REQ-031 Reset with req=4'b0000 -> grant=0, send=0, done=0 for 10 cycles.
REQ-032 req=4'b0100, req_data slice2=8'hA5 -> next cycle grant=4'b0100, data_out=8'hA5, send=1; tx_active response drops send; tx_done -> done=4'b0100 one cycle.
REQ-033 req=4'b1111 held, model answers each send -> grant sequence 0001,0010,0100,1000,0001.
REQ-034 req[1] dropped mid-BUSY -> transfer completes, done[1] pulses once.
REQ-035 arst_n low during BUSY -> next cycle grant=0, send=0, no done pulse; after release req=4'b0001 wins first.
REQ-036 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, tx_active never asserted -> err[winner] pulses in cycle 50 after START, grant=0.
